// File: rtl/cpu_defs.sv
// Shared CPU encodings: next-PC select, fetch FSM states and instruction field positions.
package cpu_defs;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        PC_NEXT     = 2'b00,
        PC_BRANCH   = 2'b01,
        PC_JUMP     = 2'b10,
        PC_REGISTER = 2'b11
    } pc_source_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_EXECUTE = 2'b10
    } fetch_state_e;

    localparam int unsigned OP_MSB     = 31;
    localparam int unsigned OP_LSB     = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_MSB  = 10;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNC_MSB   = 5;
    localparam int unsigned FUNC_LSB   = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned IMM_LSB    = 0;
    localparam int unsigned TARGET_MSB = 25;

    function automatic logic [XLEN-1:0] sign_extend_imm(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC target selection for the retiring instruction; purely combinational.
module next_pc
    import cpu_defs::*;
(
    input  logic [31:0] pc_plus_4,
    input  logic [31:0] instruction,
    input  logic [31:0] register_target,
    input  logic [1:0]  pc_source,
    output logic [31:0] target_c
);

    // The opcode never affects the target; fold it away explicitly.
    logic unused_op_c;
    assign unused_op_c = ^instruction[OP_MSB:OP_LSB];

    always_comb begin
        target_c = pc_plus_4;
        case (pc_source_e'(pc_source))
            PC_NEXT:     target_c = pc_plus_4;
            PC_BRANCH:   target_c = pc_plus_4 + (sign_extend_imm(instruction[IMM_MSB:IMM_LSB]) << 2);
            PC_JUMP:     target_c = {pc_plus_4[31:28], instruction[TARGET_MSB:0], 2'b00};
            PC_REGISTER: target_c = register_target & ~32'h0000_0003;
            default:     target_c = pc_plus_4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, fetch handshake FSM and retire counter.
module fetch_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pc_source,
    input  logic [31:0] register_target,
    input  logic        execute_stall,
    output logic        imem_request,
    output logic [31:0] imem_address,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] instruction,
    output logic        instruction_valid,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] immediate,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic [31:0] instruction_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  target_c;
    logic         fetch_done_c;
    logic         retire_c;

    assign fetch_done_c = (state_q == ST_FETCH) && imem_ready;
    assign retire_c     = (state_q == ST_EXECUTE) && !execute_stall;

    next_pc u_next_pc (
        .pc_plus_4       (pc_plus_4),
        .instruction     (instr_q),
        .register_target (register_target),
        .pc_source       (pc_source),
        .target_c        (target_c)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            count_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (fetch_done_c) begin
                    instr_d = imem_data;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (retire_c) begin
                    pc_d    = target_c;
                    count_d = count_q + 32'd1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        imem_request      = 1'b0;
        instruction_valid = 1'b0;
        case (state_q)
            ST_FETCH:   imem_request      = 1'b1;
            ST_EXECUTE: instruction_valid = 1'b1;
            default:    ;
        endcase
    end

    assign imem_address      = pc_q;
    assign pc                = pc_q;
    assign pc_plus_4         = pc_q + 32'd4;
    assign instruction       = instr_q;
    assign instruction_count = count_q;

    assign op        = instr_q[OP_MSB:OP_LSB];
    assign rs        = instr_q[RS_MSB:RS_LSB];
    assign rt        = instr_q[RT_MSB:RT_LSB];
    assign rd        = instr_q[RD_MSB:RD_LSB];
    assign shamt     = instr_q[SHAMT_MSB:SHAMT_LSB];
    assign func      = instr_q[FUNC_MSB:FUNC_LSB];
    assign immediate = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized checks of fetch_unit against an arithmetic next-PC / retire model.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  pc_source;
    logic [31:0] register_target;
    logic        execute_stall;
    logic        imem_request;
    logic [31:0] imem_address;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic        instruction_valid;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] immediate;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] instruction_count;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [31:0] m_pc;
    logic [31:0] m_count;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock             (clock),
        .reset             (reset),
        .pc_source         (pc_source),
        .register_target   (register_target),
        .execute_stall     (execute_stall),
        .imem_request      (imem_request),
        .imem_address      (imem_address),
        .imem_ready        (imem_ready),
        .imem_data         (imem_data),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .op                (op),
        .func              (func),
        .rs                (rs),
        .rt                (rt),
        .rd                (rd),
        .shamt             (shamt),
        .immediate         (immediate),
        .pc                (pc),
        .pc_plus_4         (pc_plus_4),
        .instruction_count (instruction_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference next PC written as plain 32-bit arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] instr,
                                               input logic [1:0] src, input logic [31:0] rtv);
        logic [31:0] seq;
        logic [31:0] offset;
        seq    = cur_pc + 32'd4;
        offset = ((instr & 32'h0000_FFFF) ^ 32'h0000_8000) - 32'h0000_8000;
        case (src)
            2'd0:    return seq;
            2'd1:    return seq + offset * 32'd4;
            2'd2:    return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
            default: return rtv & 32'hFFFF_FFFC;
        endcase
    endfunction

    // Starts in FETCH, ends in the FETCH of the following instruction.
    task automatic run_instr(input logic [31:0] instr, input int latency, input logic [1:0] src,
                             input logic [31:0] rtv, input int stalls);
        for (int i = 0; i < latency; i++) begin
            imem_ready = 1'b0;
            imem_data  = $urandom;
            pc_source  = 2'($urandom);
            check("req_wait", 32'(imem_request), 32'd1);
            check("addr_wait", imem_address, m_pc);
            check("valid_wait", 32'(instruction_valid), 32'd0);
            tick();
        end
        imem_ready = 1'b1;
        imem_data  = instr;
        check("req_ready", 32'(imem_request), 32'd1);
        check("addr_ready", imem_address, m_pc);
        tick();
        imem_ready = 1'b0;
        imem_data  = $urandom;
        check("field_op", 32'(op), instr >> 26);
        check("field_rs", 32'(rs), (instr >> 21) & 32'h1F);
        check("field_rt", 32'(rt), (instr >> 16) & 32'h1F);
        check("field_rd", 32'(rd), (instr >> 11) & 32'h1F);
        check("field_shamt", 32'(shamt), (instr >> 6) & 32'h1F);
        check("field_func", 32'(func), instr & 32'h3F);
        check("field_imm", 32'(immediate), instr & 32'hFFFF);
        for (int i = 0; i <= stalls; i++) begin
            execute_stall   = (i < stalls);
            pc_source       = (i < stalls) ? 2'($urandom) : src;
            register_target = (i < stalls) ? $urandom : rtv;
            check("exec_valid", 32'(instruction_valid), 32'd1);
            check("exec_req", 32'(imem_request), 32'd0);
            check("exec_instr", instruction, instr);
            check("exec_pc", pc, m_pc);
            check("exec_pc4", pc_plus_4, m_pc + 32'd4);
            check("exec_count", instruction_count, m_count);
            tick();
        end
        m_pc    = model_next(m_pc, instr, src, rtv);
        m_count = m_count + 32'd1;
        execute_stall   = 1'b0;
        pc_source       = 2'($urandom);
        register_target = $urandom;
        check("next_addr", imem_address, m_pc);
        check("next_req", 32'(imem_request), 32'd1);
        check("next_valid", 32'(instruction_valid), 32'd0);
        check("next_count", instruction_count, m_count);
    endtask

    initial begin
        reset           = 1'b1;
        pc_source       = 2'd0;
        register_target = 32'h0;
        execute_stall   = 1'b0;
        imem_ready      = 1'b0;
        imem_data       = 32'h0;
        m_pc            = 32'h0;
        m_count         = 32'h0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req", 32'(imem_request), 32'd0);
            check("rst_pc", pc, 32'h0);
            check("rst_valid", 32'(instruction_valid), 32'd0);
        end
        check("rst_instr", instruction, 32'h0);
        check("rst_count", instruction_count, 32'h0);
        check("rst_pc4", pc_plus_4, 32'h4);
        check("rst_op", 32'(op), 32'h0);
        reset = 1'b0;
        check("idle_req", 32'(imem_request), 32'd0);
        tick();
        check("first_req", 32'(imem_request), 32'd1);
        check("first_addr", imem_address, 32'h0);

        // Sequential fetch with two wait cycles (addi $t0,$zero,5)
        run_instr(32'h2008_0005, 2, 2'd0, 32'h0, 0);
        for (int i = 0; i < 3; i++) run_instr($urandom, 0, 2'd0, 32'h0, 0);
        check("at_0x10", imem_address, 32'h10);

        // Control flow: beq back to self, j, jr with misaligned register
        run_instr(32'h1000_FFFF, 1, 2'd1, 32'h0, 0);
        check("beq_target", imem_address, 32'h10);
        run_instr(32'h0800_0040, 0, 2'd2, 32'h0, 0);
        check("j_target", imem_address, 32'h100);
        run_instr($urandom, 0, 2'd3, 32'h2003, 0);
        check("jr_target", imem_address, 32'h2000);

        // Three-cycle stall
        run_instr($urandom, 1, 2'd0, 32'h0, 3);

        // PC wrap-around
        run_instr($urandom, 0, 2'd3, 32'hFFFF_FFFF, 0);
        check("pc_top", imem_address, 32'hFFFF_FFFC);
        run_instr($urandom, 0, 2'd0, 32'h0, 0);
        check("pc_wrap", imem_address, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            run_instr($urandom, int'($urandom_range(0, 3)), 2'($urandom), $urandom,
                      int'($urandom_range(0, 2)));
        end

        // Reset during FETCH with ready in the same cycle, then a late ready in IDLE
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_data  = 32'hDEAD_BEEF;
        tick();
        reset   = 1'b0;
        m_pc    = 32'h0;
        m_count = 32'h0;
        check("rf_instr", instruction, 32'h0);
        check("rf_req", 32'(imem_request), 32'd0);
        check("rf_valid", 32'(instruction_valid), 32'd0);
        check("rf_pc", pc, 32'h0);
        check("rf_count", instruction_count, 32'h0);
        imem_data = 32'h1234_5678;
        tick();
        imem_ready = 1'b0;
        check("late_instr", instruction, 32'h0);
        check("late_req", 32'(imem_request), 32'd1);
        check("late_addr", imem_address, 32'h0);
        check("late_valid", 32'(instruction_valid), 32'd0);
        run_instr($urandom, 1, 2'd0, 32'h0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
